// File: rtl/rr_merge_arbiter.sv
// rr_merge_arbiter: merges NUM_INPUTS valid/ready FIFO streams into one
// registered output stream, tagging each beat with its source channel.
// Round-robin arbitration; a granted channel may hold the output for up to
// BURST_LEN consecutive beats, then the pointer rotates past it.
// Optional: define RR_MERGE_ARBITER_STATS_EN to add the saturating
// o_stall_count and per-channel o_grant_count counters.

`ifdef RR_MERGE_ARBITER_STATS_EN
// Per-lane 16-bit saturating event counter.
module rr_merge_sat_cnt (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_inc,
  output logic [15:0] o_count
);
  // Count events, sticking at all-ones.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)                      o_count <= '0;
    else if (i_inc && o_count != 16'hFFFF) o_count <= o_count + 16'd1;
  end
endmodule
`endif

module rr_merge_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic [NUM_INPUTS*WIDTH-1:0]   i_in_data,
  input  logic [NUM_INPUTS-1:0]         i_in_valid,
  output logic [NUM_INPUTS-1:0]         o_in_ready,
  output logic [WIDTH-1:0]              o_out_data,
  output logic [$clog2(NUM_INPUTS)-1:0] o_out_channel,
  output logic                          o_out_valid,
  input  logic                          i_out_ready
`ifdef RR_MERGE_ARBITER_STATS_EN
  ,
  output logic [15:0]                   o_stall_count,
  output logic [NUM_INPUTS*16-1:0]      o_grant_count
`endif
);

  localparam int         CW = $clog2(NUM_INPUTS);
  localparam logic [7:0] BL = 8'(BURST_LEN);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] ptr;
  logic [CW-1:0] owner;
  logic [CW-1:0] owner_inc;
  logic [7:0]    bcnt;

  logic [CW-1:0] grant;
  logic          grant_valid;
  logic          load;
  logic          xfer;
  logic [CW-1:0] idx;
  int            sum;

  logic [NUM_INPUTS-1:0][WIDTH-1:0] in_vec;
  assign in_vec = i_in_data;

  // Output register can take a beat when empty or being drained this cycle.
  assign load = !o_out_valid || i_out_ready;
  assign xfer = load && grant_valid;

  assign owner_inc = (owner == CW'(NUM_INPUTS - 1)) ? '0 : owner + 1'b1;

  // Grant select: the burst owner in HOLD, else the first valid from ptr.
  // The IDLE search runs highest offset first so the lowest offset wins.
  always_comb begin
    grant       = owner;
    grant_valid = 1'b0;
    idx         = '0;
    sum         = 0;
    if (state == ST_HOLD) begin
      grant_valid = i_in_valid[owner] && (bcnt < BL);
    end else begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        sum = int'(ptr) + i;
        if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
        idx = CW'(sum);
        if (i_in_valid[idx]) begin
          grant       = idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  // One-hot pop to the granted FIFO; silent while reset is held.
  always_comb begin
    o_in_ready = '0;
    if (i_reset_n && xfer) o_in_ready[grant] = 1'b1;
  end

  // Arbitration state; frozen whenever the output register is stalled.
  // In HOLD, the absence of a grant means either the owner ran dry or the
  // burst is complete, and both leave for IDLE past the owner.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
      bcnt  <= '0;
    end else if (load) begin
      if (state == ST_IDLE) begin
        if (xfer) begin
          state <= ST_HOLD;
          owner <= grant;
          bcnt  <= 8'd1;
        end
      end else if (xfer) begin
        bcnt <= bcnt + 8'd1;
      end else begin
        state <= ST_IDLE;
        ptr   <= owner_inc;
        bcnt  <= '0;
      end
    end
  end

  // Registered output stage; data/channel only move when a beat lands.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_out_valid   <= 1'b0;
      o_out_data    <= '0;
      o_out_channel <= '0;
    end else if (load) begin
      o_out_valid <= xfer;
      if (xfer) begin
        o_out_data    <= in_vec[grant];
        o_out_channel <= grant;
      end
    end
  end

`ifdef RR_MERGE_ARBITER_STATS_EN
  logic [NUM_INPUTS-1:0][15:0] gcnt;
  assign o_grant_count = gcnt;

  rr_merge_sat_cnt u_stall (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_inc     (o_out_valid && !i_out_ready),
    .o_count   (o_stall_count)
  );

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_gcnt
    rr_merge_sat_cnt u_gcnt (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_inc     (xfer && (grant == CW'(g))),
      .o_count   (gcnt[g])
    );
  end
`endif

endmodule

// File: tb/tb_rr_merge_arbiter.sv
// Bench for rr_merge_arbiter: table-driven single-channel burst, directed
// corner sequences, and randomized traffic against a behavioural model.
// Each channel acts as a FIFO whose next beat is {channel, sequence}.
module tb_rr_merge_arbiter;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int BL = 4;

  logic             i_clock = 1'b0;
  logic             i_reset_n = 1'b0;
  logic [N*W-1:0]   i_in_data = '0;
  logic [N-1:0]     i_in_valid = '0;
  logic [N-1:0]     o_in_ready;
  logic [W-1:0]     o_out_data;
  logic [2:0]       o_out_channel;
  logic             o_out_valid;
  logic             i_out_ready = 1'b0;
`ifdef RR_MERGE_ARBITER_STATS_EN
  logic [15:0]      o_stall_count;
  logic [N*16-1:0]  o_grant_count;
`endif

  rr_merge_arbiter #(.WIDTH(W), .NUM_INPUTS(N), .BURST_LEN(BL)) dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_in_data     (i_in_data),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .o_out_data    (o_out_data),
    .o_out_channel (o_out_channel),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready)
`ifdef RR_MERGE_ARBITER_STATS_EN
    ,
    .o_stall_count (o_stall_count),
    .o_grant_count (o_grant_count)
`endif
  );

  always #5 i_clock = ~i_clock;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model: who owns the output, how many beats it has had,
  // where the round-robin search starts, and what sits in the output slot.
  int         m_ptr, m_own, m_cnt, m_ch, m_stall;
  bit         m_ov;
  logic [7:0] m_data;
  int         m_gc[N];
  int         seq[N];

  logic [7:0] s_rdy, s_data;
  logic       s_ov;
  logic [2:0] s_ch;

  typedef struct {
    logic [7:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_data;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_own = -1; m_cnt = 0; m_ov = 0; m_data = '0; m_ch = 0; m_stall = 0;
    for (int k = 0; k < N; k++) m_gc[k] = 0;
  endtask

  // One cycle, entered and left just after a falling edge.
  task automatic cyc(input logic [7:0] v, input logic r);
    int         g;
    logic       ld;
    logic [7:0] er;
    i_in_valid  = v;
    i_out_ready = r;
    for (int k = 0; k < N; k++) i_in_data[k*W +: W] = 8'((k << 4) | (seq[k] & 15));
    #1;
    s_rdy = o_in_ready; s_ov = o_out_valid; s_data = o_out_data; s_ch = o_out_channel;
    chk("out_valid", 32'(s_ov), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(s_data), 32'(m_data));
      chk("out_channel", 32'(s_ch), 32'(m_ch));
    end
`ifdef RR_MERGE_ARBITER_STATS_EN
    chk("stall_count", 32'(o_stall_count), 32'(m_stall));
    for (int k = 0; k < N; k++) chk("grant_count", 32'(o_grant_count[k*16 +: 16]), 32'(m_gc[k]));
`endif
    ld = !m_ov || r;
    g  = -1;
    if (ld) begin
      if (m_own >= 0) begin
        if (m_cnt < BL && v[m_own]) g = m_own;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    er = (g >= 0) ? 8'(1 << g) : 8'h00;
    chk("in_ready", 32'(s_rdy), 32'(er));
    if (m_ov && !r && m_stall < 65535) m_stall++;
    if (g >= 0 && m_gc[g] < 65535) m_gc[g]++;
    if (ld) begin
      if (g >= 0) begin
        m_data = 8'((g << 4) | (seq[g] & 15));
        m_ch   = g;
        seq[g]++;
        if (m_own < 0) begin m_own = g; m_cnt = 1; end
        else m_cnt++;
      end else if (m_own >= 0) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end
      m_ov = (g >= 0);
    end
    @(negedge i_clock);
  endtask

  task automatic do_reset();
    i_reset_n  = 1'b0;
    i_in_valid = '0;
    model_reset();
    for (int k = 0; k < N; k++) seq[k] = 0;
    repeat (2) @(negedge i_clock);
    i_reset_n = 1'b1;
  endtask

  logic [7:0] held;

  initial begin
    // Single-channel burst on ch3: 10 beats, bubble after every 4th.
    tbl[0]  = '{8'h08, 1'b0, 8'h00};
    tbl[1]  = '{8'h08, 1'b1, 8'h30};
    tbl[2]  = '{8'h08, 1'b1, 8'h31};
    tbl[3]  = '{8'h08, 1'b1, 8'h32};
    tbl[4]  = '{8'h00, 1'b1, 8'h33};
    tbl[5]  = '{8'h08, 1'b0, 8'h00};
    tbl[6]  = '{8'h08, 1'b1, 8'h34};
    tbl[7]  = '{8'h08, 1'b1, 8'h35};
    tbl[8]  = '{8'h08, 1'b1, 8'h36};
    tbl[9]  = '{8'h00, 1'b1, 8'h37};
    tbl[10] = '{8'h08, 1'b0, 8'h00};
    tbl[11] = '{8'h08, 1'b1, 8'h38};
    tbl[12] = '{8'h00, 1'b1, 8'h39};
    tbl[13] = '{8'h00, 1'b0, 8'h00};

    // Reset held with every channel valid.
    model_reset();
    for (int k = 0; k < N; k++) seq[k] = 0;
    i_in_valid  = 8'hFF;
    i_out_ready = 1'b1;
    repeat (3) @(negedge i_clock);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_out_data", 32'(o_out_data), 32'd0);
    chk("rst_out_channel", 32'(o_out_channel), 32'd0);
    i_reset_n = 1'b1;
    cyc(8'hFF, 1'b1);
    chk("first_grant", 32'(s_rdy), 32'h01);
    cyc(8'hFF, 1'b1);
    chk("first_out_valid", 32'(s_ov), 32'd1);
    chk("first_out_channel", 32'(s_ch), 32'd0);

    // Table-driven ch3 burst.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      cyc((seq[3] < 10) ? 8'h08 : 8'h00, 1'b1);
      chk($sformatf("tbl%0d_rdy", c), 32'(s_rdy), 32'(tbl[c].exp_rdy));
      chk($sformatf("tbl%0d_ov", c), 32'(s_ov), 32'(tbl[c].exp_ov));
      if (tbl[c].exp_ov) begin
        chk($sformatf("tbl%0d_data", c), 32'(s_data), 32'(tbl[c].exp_data));
        chk($sformatf("tbl%0d_ch", c), 32'(s_ch), 32'd3);
      end
    end
`ifdef RR_MERGE_ARBITER_STATS_EN
    for (int k = 0; k < N; k++)
      chk($sformatf("gcnt%0d", k), 32'(o_grant_count[k*16 +: 16]), (k == 3) ? 32'd10 : 32'd0);
`endif

    // All channels valid: BL beats per channel, one bubble, strict rotation.
    do_reset();
    for (int c = 0; c < 2 * N * (BL + 1); c++) begin
      cyc(8'hFF, 1'b1);
      chk("rotate_rdy", 32'(s_rdy),
          ((c % (BL + 1)) < BL) ? 32'(1 << ((c / (BL + 1)) % N)) : 32'd0);
    end

    // Backpressure for 5 cycles mid-burst; burst resumes where it stopped.
    do_reset();
    cyc(8'h01, 1'b1);
    cyc(8'h01, 1'b1);
    held = 8'h01;
    for (int c = 0; c < 5; c++) begin
      cyc(8'h01, 1'b0);
      chk("bp_rdy", 32'(s_rdy), 32'd0);
      chk("bp_data", 32'(s_data), 32'(held));
      chk("bp_ch", 32'(s_ch), 32'd0);
    end
    cyc(8'h01, 1'b1); chk("bp_resume0", 32'(s_rdy), 32'h01);
    cyc(8'h01, 1'b1); chk("bp_resume1", 32'(s_rdy), 32'h01);
    cyc(8'h01, 1'b1); chk("bp_burst_end", 32'(s_rdy), 32'h00);
    cyc(8'h01, 1'b1); chk("bp_regrant", 32'(s_rdy), 32'h01);

`ifdef RR_MERGE_ARBITER_STATS_EN
    // Exactly three stalled cycles.
    do_reset();
    cyc(8'h01, 1'b1);
    repeat (3) cyc(8'h00, 1'b0);
    cyc(8'h00, 1'b1);
    chk("stall3", 32'(o_stall_count), 32'd3);
`endif

    // Early burst end on ch5 hands over to ch6; then an async reset pulse.
    do_reset();
    cyc(8'h60, 1'b1); chk("early_g0", 32'(s_rdy), 32'h20);
    cyc(8'h60, 1'b1); chk("early_g1", 32'(s_rdy), 32'h20);
    cyc(8'h40, 1'b1); chk("early_exit", 32'(s_rdy), 32'h00);
    cyc(8'h40, 1'b1); chk("early_next", 32'(s_rdy), 32'h40);
    cyc(8'h40, 1'b1);
    i_reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(o_out_valid), 32'd0);
    chk("arst_in_ready", 32'(o_in_ready), 32'd0);
    #1;
    i_reset_n = 1'b1;
    model_reset();
    cyc(8'h41, 1'b1); chk("arst_ptr0", 32'(s_rdy), 32'h01);

    // Randomized traffic and backpressure.
    do_reset();
    for (int c = 0; c < 800; c++)
      cyc(8'($urandom) & 8'($urandom), ($urandom_range(0, 3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
